// File: rtl/board_mem_arbiter_if.sv
// Board RAM arbitration bus: six requesters (four ghosts, pacman, painter) plus the RAM port.
interface board_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 4
);
    logic [2:0]          select;
    logic [5:0]          req;
    logic [5:0]          we;
    logic [6*ADDR_W-1:0] addr_in;
    logic [6*DATA_W-1:0] wdata_in;
    logic [5:0]          grant;
    logic [5:0]          ack;
    logic [DATA_W-1:0]   rdata;
    logic                busy;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;

    modport slave (
        input  select, req, we, addr_in, wdata_in, mem_rdata,
        output grant, ack, rdata, busy, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output select, req, we, addr_in, wdata_in, mem_rdata,
        input  grant, ack, rdata, busy, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/board_mem_arbiter.sv
// Board RAM arbiter: phase-priority with round-robin fallback, one access per 4 cycles
// through IDLE -> ISSUE -> WAIT -> DONE.
module board_mem_arbiter #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 4
) (
    input logic                 clk,
    input logic                 reset,
    board_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e              state_q, state_d;
    logic [5:0]          grant_q;
    logic [2:0]          last_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                we_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [2:0]          win;
    logic                capture;
    logic                latch_rd;

    // Phase owner wins outright; otherwise the nearest requester after last_q.
    always_comb begin
        win = last_q;
        if (bus.select < 3'd6 && bus.req[bus.select]) begin
            win = bus.select;
        end else begin
            for (int k = 6; k >= 1; k--) begin
                automatic int idx = (int'(last_q) + k) % 6;
                if (bus.req[3'(idx)]) begin
                    win = 3'(idx);
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        latch_rd = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|bus.req) begin
                    capture = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                latch_rd = ~we_q;
                state_d  = StDone;
            end
            StDone: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= 3'd5;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                grant_q <= 6'd1 << win;
                last_q  <= win;
                addr_q  <= bus.addr_in[int'(win)*ADDR_W +: ADDR_W];
                wdata_q <= bus.wdata_in[int'(win)*DATA_W +: DATA_W];
                we_q    <= bus.we[win];
            end else if (state_q == StDone) begin
                grant_q <= '0;
            end
            if (latch_rd) begin
                rdata_q <= bus.mem_rdata;
            end
        end
    end

    // Captured operands drive the RAM port directly, so mem_addr holds between accesses.
    assign bus.grant     = grant_q;
    assign bus.ack       = (state_q == StDone) ? grant_q : 6'd0;
    assign bus.busy      = (state_q != StIdle);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_we    = (state_q == StIssue) && we_q;
    assign bus.rdata     = rdata_q;
endmodule

// File: tb/tb_board_mem_arbiter.sv
// Self-checking bench for board_mem_arbiter: vector table of arbitrations plus
// hand-written sequences for request drop and mid-transaction reset.
module tb_board_mem_arbiter;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 4;

    typedef struct {
        logic [2:0] sel;
        logic [5:0] req;
        logic [5:0] we;
        logic [9:0] abase;
        logic [3:0] wbase;
        int         idx;
    } vec_t;

    typedef struct {
        int         idx;
        logic       we;
        logic [9:0] addr;
        logic [3:0] wdata;
        logic [3:0] rdata;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   we_cnt;
    exp_t sb[$];
    logic [3:0] shadow [1024];
    logic [3:0] ram [1024];
    logic [3:0] exp_rdata;
    vec_t vecs [19];

    board_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    board_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] init_val(input int a);
        return 4'(a) ^ 4'h9;
    endfunction

    // Board RAM: one-cycle synchronous read, reloaded with known contents under reset.
    always @(posedge clk) begin
        if (reset) begin
            for (int a = 0; a < 1024; a++) ram[a] <= init_val(a);
        end else if (bus.mem_we) begin
            ram[bus.mem_addr] <= bus.mem_wdata;
        end
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req_v);
        end
    endtask

    task automatic monitor();
        exp_t e;
        check("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
        check("ack_onehot0", 32'($onehot0(bus.ack)), 32'd1);
        if (bus.mem_we) we_cnt++;
        if (bus.ack != 6'd0) begin
            if (sb.size() == 0) begin
                check("ack_unexpected", 32'(bus.ack), 32'd0);
            end else begin
                e = sb.pop_front();
                check("ack_owner", 32'(bus.ack), 32'(6'd1 << e.idx));
                check("rdata", 32'(bus.rdata), 32'(e.rdata));
                check("mem_addr_hold", 32'(bus.mem_addr), 32'(e.addr));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        monitor();
    endtask

    task automatic reset_model();
        for (int a = 0; a < 1024; a++) shadow[a] = init_val(a);
        exp_rdata = 4'd0;
        sb.delete();
    endtask

    task automatic drive(input logic [2:0] sel, input logic [5:0] rq, input logic [5:0] w,
                         input logic [9:0] abase, input logic [3:0] wbase);
        bus.select = sel;
        bus.req    = rq;
        bus.we     = w;
        for (int i = 0; i < 6; i++) begin
            bus.addr_in[i*10 +: 10] = 10'(int'(abase) + i*17);
            bus.wdata_in[i*4 +: 4]  = 4'(int'(wbase) + i);
        end
    endtask

    // One full transaction; exp_gt is the tick on which grant should first appear.
    task automatic run_txn(input logic [2:0] sel, input logic [5:0] rq, input logic [5:0] w,
                           input logic [9:0] abase, input logic [3:0] wbase, input int idx,
                           input int exp_gt, input bit drop);
        exp_t e;
        int gt;
        int at;
        drive(sel, rq, w, abase, wbase);
        e.idx   = idx;
        e.we    = w[3'(idx)];
        e.addr  = 10'(int'(abase) + idx*17);
        e.wdata = 4'(int'(wbase) + idx);
        if (e.we) shadow[e.addr] = e.wdata;
        else exp_rdata = shadow[e.addr];
        e.rdata = exp_rdata;
        sb.push_back(e);
        we_cnt = 0;
        gt = -1;
        at = -1;
        for (int t = 1; t <= 8 && at < 0; t++) begin
            tick();
            if (gt < 0 && bus.grant != 6'd0) begin
                gt = t;
                check("grant", 32'(bus.grant), 32'(6'd1 << idx));
                check("issue_mem_we", 32'(bus.mem_we), 32'(e.we));
                check("issue_mem_addr", 32'(bus.mem_addr), 32'(e.addr));
                if (e.we) check("issue_mem_wdata", 32'(bus.mem_wdata), 32'(e.wdata));
                if (drop) begin
                    bus.req      = 6'd0;
                    bus.select   = (idx == 0) ? 3'd1 : 3'd0;
                    bus.addr_in  = ~bus.addr_in;
                    bus.wdata_in = ~bus.wdata_in;
                end
            end
            if (bus.ack != 6'd0) at = t;
        end
        if (at < 0 || gt < 0) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout grant_tick=%0d ack_tick=%0d required_owner=%0d", gt, at, idx);
            sb.delete();
        end else begin
            check("grant_latency", 32'(gt), 32'(exp_gt));
            check("ack_latency", 32'(at - gt), 32'd2);
        end
        check("mem_we_pulses", 32'(we_cnt), 32'(e.we));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        we_cnt   = 0;
        vecs[0]  = '{3'd7, 6'h01, 6'h00, 10'h05A, 4'h0, 0};
        vecs[1]  = '{3'd7, 6'h20, 6'h20, 10'h0AB, 4'hA, 5};
        vecs[2]  = '{3'd5, 6'h20, 6'h00, 10'h0AB, 4'h0, 5};
        vecs[3]  = '{3'd6, 6'h3F, 6'h00, 10'h300, 4'h0, 0};
        vecs[4]  = '{3'd6, 6'h3F, 6'h00, 10'h300, 4'h0, 1};
        vecs[5]  = '{3'd6, 6'h3F, 6'h00, 10'h300, 4'h0, 2};
        vecs[6]  = '{3'd6, 6'h3F, 6'h00, 10'h300, 4'h0, 3};
        vecs[7]  = '{3'd6, 6'h3F, 6'h00, 10'h300, 4'h0, 4};
        vecs[8]  = '{3'd6, 6'h3F, 6'h00, 10'h300, 4'h0, 5};
        vecs[9]  = '{3'd6, 6'h3F, 6'h00, 10'h300, 4'h0, 0};
        vecs[10] = '{3'd2, 6'h3F, 6'h04, 10'h200, 4'h3, 2};
        vecs[11] = '{3'd2, 6'h3F, 6'h00, 10'h200, 4'h0, 2};
        vecs[12] = '{3'd2, 6'h3B, 6'h00, 10'h040, 4'h0, 3};
        vecs[13] = '{3'd4, 6'h03, 6'h00, 10'h040, 4'h0, 0};
        vecs[14] = '{3'd7, 6'h08, 6'h00, 10'h100, 4'h0, 3};
        vecs[15] = '{3'd0, 6'h30, 6'h00, 10'h100, 4'h0, 4};
        vecs[16] = '{3'd1, 6'h2A, 6'h02, 10'h380, 4'h7, 1};
        vecs[17] = '{3'd6, 6'h2A, 6'h00, 10'h380, 4'h0, 3};
        vecs[18] = '{3'd7, 6'h22, 6'h00, 10'h380, 4'h0, 5};

        reset = 1'b1;
        drive(3'd7, 6'd0, 6'd0, 10'h000, 4'h0);
        reset_model();
        tick();
        tick();
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_rdata", 32'(bus.rdata), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            run_txn(vecs[i].sel, vecs[i].req, vecs[i].we, vecs[i].abase, vecs[i].wbase,
                    vecs[i].idx, (i == 0) ? 1 : 2, 1'b0);
        end

        // Request and operands withdrawn right after grant: transaction still completes.
        run_txn(3'd7, 6'h02, 6'h00, 10'h150, 4'h0, 1, 2, 1'b1);
        tick();
        tick();
        check("drop_no_regrant", 32'(bus.grant), 32'd0);
        check("drop_idle", 32'(bus.busy), 32'd0);

        // Reset while in WAIT abandons the access.
        drive(3'd7, 6'h04, 6'h00, 10'h020, 4'h0);
        tick();
        check("pre_rst_grant", 32'(bus.grant), 32'h04);
        tick();
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        bus.req = 6'd0;
        reset_model();
        tick();
        check("mid_rst_grant", 32'(bus.grant), 32'd0);
        check("mid_rst_ack", 32'(bus.ack), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("mid_rst_rdata", 32'(bus.rdata), 32'd0);
        reset = 1'b0;
        tick();
        tick();
        check("post_rst_idle", 32'(bus.busy), 32'd0);
        // last_winner back at 5: requester 1 beats 3.
        run_txn(3'd7, 6'h0A, 6'h00, 10'h060, 4'h0, 1, 1, 1'b0);
        run_txn(3'd7, 6'h02, 6'h00, 10'h070, 4'h0, 1, 2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
